// File: rtl/dca_matrix_lsu_rreq_scheduler_pkg.sv
// Constants shared by the DCA matrix LSU read-request scheduler and the row collector.
// Covers the txn-info word layout, the bit-address width and the scheduler state encoding.
package dca_lsu_lpara;

  localparam int BW_BITADDR     = 35;
  localparam int BW_ARLEN       = 8;

  // txn_info = {is_last_row, 1'b0, arlen, bitaddr}
  localparam int TI_BITADDR_LSB = 0;
  localparam int TI_ARLEN_LSB   = TI_BITADDR_LSB + BW_BITADDR;
  localparam int TI_RSVD_BIT    = TI_ARLEN_LSB + BW_ARLEN;
  localparam int TI_LAST_BIT    = TI_RSVD_BIT + 1;
  localparam int BW_TXN_INFO    = TI_LAST_BIT + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rreq_state_e;

endpackage

// File: rtl/dca_matrix_lsu_rreq_scheduler_txn_fifo.sv
// First-word-fall-through FIFO holding txn-info words until the row collector takes them.
// The head reads as zero while the FIFO is empty.
module dca_matrix_lsu_txn_fifo
  import dca_lsu_lpara::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BW_TXN_INFO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int BW_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW_CNT = $clog2(DEPTH + 1);
  localparam logic [BW_PTR-1:0] LAST_PTR = BW_PTR'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [BW_PTR-1:0] wr_ptr;
  logic [BW_PTR-1:0] rd_ptr;
  logic [BW_CNT-1:0] count;
  logic              do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dca_matrix_lsu_rreq_scheduler.sv
// Turns one matrix-load command into one AXI AR burst per row plus a matching txn-info word.
// state | meaning:  IDLE | waiting for a command;  ISSUE | sending row bursts;  DRAIN | waiting for the last rows to complete.
module dca_matrix_lsu_rreq_scheduler
  import dca_lsu_lpara::*;
#(
  parameter int BW_ADDR          = 32,
  parameter int MAX_NUM_AXI_DATA = 4,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int BW_NUM_ROW       = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [BW_ADDR-1:0]                    cmd_base_addr,
  input  logic [BW_ADDR-1:0]                    cmd_stride,
  input  logic [BW_NUM_ROW-1:0]                 cmd_num_row,
  input  logic [$clog2(MAX_NUM_AXI_DATA+1)-1:0] cmd_num_beat,
  output logic [BW_ADDR-1:0]                    araddr,
  output logic [7:0]                            arlen,
  output logic                                  arvalid,
  input  logic                                  arready,
  output logic                                  txn_info_valid,
  input  logic                                  txn_info_ready,
  output logic [BW_TXN_INFO-1:0]                txn_info,
  input  logic                                  row_done,
  output logic                                  busy,
  output logic                                  done
);

  localparam int BW_NUM_BEAT = $clog2(MAX_NUM_AXI_DATA + 1);
  localparam int BW_OUT      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [BW_OUT-1:0]      MAX_OUT  = BW_OUT'(MAX_OUTSTANDING);
  localparam logic [BW_NUM_BEAT-1:0] MAX_BEAT = BW_NUM_BEAT'(MAX_NUM_AXI_DATA);

  rreq_state_e            state;
  rreq_state_e            state_nxt;
  logic [BW_ADDR-1:0]     addr;
  logic [BW_ADDR-1:0]     stride_q;
  logic [BW_NUM_ROW-1:0]  num_row_q;
  logic [BW_NUM_ROW-1:0]  row_cnt;
  logic [BW_ARLEN-1:0]    arlen_q;
  logic [BW_OUT-1:0]      outstanding;
  logic                   zero_done_q;
  logic                   cmd_hs;
  logic                   ar_hs;
  logic                   row_dec;
  logic                   is_last_row;
  logic                   drain_done;
  logic                   fifo_empty;
  logic [BW_NUM_BEAT-1:0] beat_clamped;
  logic [BW_ADDR+2:0]     bitaddr_full;
  logic [BW_TXN_INFO-1:0] txn_word;
  logic [BW_TXN_INFO-1:0] fifo_head;

  // rst gates cmd_ready so every output reads zero while reset is held
  assign cmd_ready   = (state == IDLE) && enable && !rst;
  assign cmd_hs      = cmd_valid && cmd_ready;
  assign arvalid     = (state == ISSUE) && enable && (outstanding < MAX_OUT);
  assign ar_hs       = arvalid && arready;
  assign row_dec     = row_done && enable && (outstanding != '0);
  assign is_last_row = (row_cnt == num_row_q - 1'b1);
  assign drain_done  = (state == DRAIN) && enable && (outstanding == '0);

  assign araddr         = addr;
  assign arlen          = arlen_q;
  assign busy           = (state != IDLE);
  assign done           = drain_done || (zero_done_q && enable);
  assign txn_info_valid = !fifo_empty && enable;
  assign txn_info       = fifo_head;

  assign bitaddr_full = {addr, 3'b000};
  assign txn_word     = {is_last_row, 1'b0, arlen_q, BW_BITADDR'(bitaddr_full)};

  always_comb begin
    beat_clamped = cmd_num_beat;
    if (cmd_num_beat == '0)            beat_clamped = BW_NUM_BEAT'(1);
    else if (cmd_num_beat > MAX_BEAT)  beat_clamped = MAX_BEAT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_hs && (cmd_num_row != '0)) state_nxt = ISSUE;
      ISSUE:   if (ar_hs && is_last_row)          state_nxt = DRAIN;
      DRAIN:   if (drain_done)                    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      stride_q    <= '0;
      num_row_q   <= '0;
      row_cnt     <= '0;
      arlen_q     <= '0;
      outstanding <= '0;
      zero_done_q <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr      <= cmd_base_addr;
        stride_q  <= cmd_stride;
        num_row_q <= cmd_num_row;
        arlen_q   <= BW_ARLEN'(beat_clamped - BW_NUM_BEAT'(1));
        row_cnt   <= '0;
      end else if (ar_hs) begin
        addr    <= addr + stride_q;
        row_cnt <= row_cnt + 1'b1;
      end
      // a zero-row command completes without leaving IDLE
      if (enable) zero_done_q <= cmd_hs && (cmd_num_row == '0);
      case ({ar_hs, row_dec})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  dca_matrix_lsu_txn_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (BW_TXN_INFO)
  ) u_txn_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ar_hs),
    .push_data (txn_word),
    .pop       (txn_info_valid && txn_info_ready),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

endmodule
